// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_mod(input int f, input int baud);
    return (f + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_counter.sv
// Free-running modulo-N counter with synchronous clear and count enable.
module uart_tx_counter #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (ce)
      count <= (count == LAST) ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte stream in, 8-bit frame with optional
// parity and 1 or 2 stop bits out on a registered, idle-high line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int F         = 8000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int MOD = calc_mod(F, BAUD);
  localparam int TW  = $clog2(MOD);
  localparam logic [TW-1:0] BIT_LAST = TW'(MOD - 1);

  if (MOD < 2 || PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx: illegal parameters MOD=%0d PARITY=%0d STOP_BITS=%0d",
           MOD, PARITY, STOP_BITS);
  end

  tx_state_e     state, state_nx;
  logic [TW-1:0] timer;
  logic          bit_end;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic          stop_cnt, stop_last;
  logic [7:0]    data_q, data_nx;
  logic          par_q, par_nx;
  logic          accept;
  logic          tx_nx;

  function automatic logic frame_parity(input logic [7:0] d);
    return (^d) ^ (PARITY == PAR_ODD);
  endfunction

  // Bit timer restarts whenever the state changes.
  uart_tx_counter #(.N(MOD), .W(TW)) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .ce    (1'b1),
    .clr   (state_nx != state),
    .count (timer)
  );

  assign bit_end   = (timer == BIT_LAST);
  assign stop_last = (int'(stop_cnt) == STOP_BITS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (tx_valid) state_nx = ST_START;
      ST_START:  if (bit_end) state_nx = ST_DATA;
      ST_DATA:   if (bit_end && bit_idx == 3'd7)
                   state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nx = ST_STOP;
      ST_STOP:   if (bit_end && stop_last)
                   state_nx = tx_valid ? ST_START : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // The line level is computed for the state being entered so tx moves
  // on the same edge as the state change.
  always_comb begin
    tx_ready   = (state == ST_IDLE) || (state == ST_STOP && stop_last && bit_end);
    busy       = (state != ST_IDLE);
    accept     = tx_valid && tx_ready;
    data_nx    = accept ? tx_data : data_q;
    par_nx     = accept ? frame_parity(tx_data) : par_q;
    bit_idx_nx = bit_idx;
    if (accept)
      bit_idx_nx = 3'd0;
    else if (state == ST_DATA && bit_end)
      bit_idx_nx = bit_idx + 3'd1;
    tx_nx = 1'b1;
    case (state_nx)
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = data_nx[bit_idx_nx];
      ST_PARITY: tx_nx = par_nx;
      default:   tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
    end else begin
      bit_idx <= bit_idx_nx;
      tx      <= tx_nx;
      if (state == ST_STOP && bit_end)
        stop_cnt <= ~stop_last;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_nx;
    par_q  <= par_nx;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, even parity, odd parity, two stop bits)
// checked every cycle against a frame-timing model plus directed literal checks.
module tb_uart_tx;

  localparam int MOD = 10;
  localparam int HN  = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valid = '0;
  logic [7:0] data [4];
  logic [3:0] tx_o, rdy, bsy;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    uart_tx #(
      .F         (1000),
      .BAUD      (100),
      .PARITY    ((gi == 1) ? 2 : ((gi == 2) ? 1 : 0)),
      .STOP_BITS ((gi == 3) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (data[gi]),
      .tx_valid (valid[gi]),
      .tx_ready (rdy[gi]),
      .tx       (tx_o[gi]),
      .busy     (bsy[gi])
    );
  end

  // Model: a frame occupies flen cycles starting at the accept edge.
  int         par_cfg [4] = '{0, 2, 1, 0};
  int         stop_cfg[4] = '{1, 1, 1, 2};
  int         n = 0;
  int         next_ok[4] = '{default: 0};
  int         start_e[4] = '{default: 0};
  logic [7:0] frame  [4];

  function automatic int flen(input int i);
    return MOD * (9 + ((par_cfg[i] != 0) ? 1 : 0) + stop_cfg[i]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) next_ok[i] <= 0;
    end else begin
      n <= n + 1;
      for (int i = 0; i < 4; i++)
        if (valid[i] && n + 1 >= next_ok[i]) begin
          start_e[i] <= n + 1;
          next_ok[i] <= n + 1 + flen(i);
          frame[i]   <= data[i];
        end
    end
  end

  function automatic int exp_tx(input int i, input int c);
    int k;
    if (c >= next_ok[i]) return 1;
    k = (c - start_e[i]) / MOD;
    if (k == 0) return 0;
    if (k <= 8) return int'(frame[i][k-1]);
    if (k == 9 && par_cfg[i] != 0) return int'((^frame[i]) ^ (par_cfg[i] == 1));
    return 1;
  endfunction

  logic hist [4][HN];
  logic rhist[4][HN];
  logic bhist[4][HN];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int hget(input int sel, input int i, input int c);
    if (c < 0 || c >= HN) return -1;
    case (sel)
      0:       return int'(hist[i][c]);
      1:       return int'(rhist[i][c]);
      default: return int'(bhist[i][c]);
    endcase
  endfunction

  function automatic int decode(input int i, input int a);
    int r = 0;
    for (int j = 0; j < 8; j++)
      if (hget(0, i, a + MOD * (j + 1) + MOD / 2) == 1) r = r | (1 << j);
    return r;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] at cycle %0d: got %0d, want %0d", name, idx, n, act, exp);
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [7:0] b, input bit keep, output int acc);
    bit done = 0;
    acc = -1;
    data[i]  = b;
    valid[i] = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (rdy[i]) begin
        @(posedge clk);
        #2;
        acc  = n;
        done = 1;
      end
    end
    if (!keep) valid[i] = 1'b0;
    if (!done) check("accept_timeout", i, 0, 1);
  endtask

  int a, b, r, cnt, k;
  int acc_e[3];
  int acc_d[3];

  initial begin
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (n < HN) begin
            hist[i][n]  = tx_o[i];
            rhist[i][n] = rdy[i];
            bhist[i][n] = bsy[i];
          end
          check("tx", i, int'(tx_o[i]), exp_tx(i, n));
          check("tx_ready", i, int'(rdy[i]), (n + 1 >= next_ok[i]) ? 1 : 0);
          check("busy", i, int'(bsy[i]), (n < next_ok[i]) ? 1 : 0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_tx", 0, int'(tx_o[0]), 1);
    check("rst_ready", 0, int'(rdy[0]), 1);
    check("rst_busy", 0, int'(bsy[0]), 0);
    wait_cycles(2);

    // 0x55 on the default 8N1 instance
    send(0, 8'h55, 0, a);
    wait_cycles(120);
    for (int j = 0; j < 10; j++) check("t1_bit", j, hget(0, 0, a + MOD * j + 5), j % 2);
    check("t1_idle_after", 0, hget(0, 0, a + 105), 1);
    cnt = 0;
    for (int c = a; c < a + 200 && hget(1, 0, c) == 0; c++) cnt++;
    check("t1_ready_low", 0, cnt, 99);

    // back-to-back frames with tx_valid held
    send(0, 8'hA5, 1, a);
    send(0, 8'h3C, 0, b);
    wait_cycles(120);
    check("t2_gap", 0, b - a, 100);
    check("t2_start2", 0, hget(0, 0, b), 0);
    check("t2_byte0", 0, decode(0, a), 'hA5);
    check("t2_byte1", 0, decode(0, b), 'h3C);
    cnt = 0;
    for (int c = a; c < b + 100; c++) cnt += (hget(2, 0, c) == 1) ? 1 : 0;
    check("t2_busy", 0, cnt, 200);

    // parity: even on instance 1, odd on instance 2
    send(1, 8'h07, 0, a);
    send(2, 8'h07, 0, b);
    wait_cycles(130);
    check("t3_even_par", 1, hget(0, 1, a + 95), 1);
    check("t3_odd_par", 2, hget(0, 2, b + 95), 0);
    check("t3_byte", 1, decode(1, a), 'h07);
    check("t3_stop", 1, hget(0, 1, a + 105), 1);
    check("t3_ready_pre", 1, hget(1, 1, a + 108), 0);
    check("t3_ready_end", 1, hget(1, 1, a + 109), 1);
    check("t3_ready_pre", 2, hget(1, 2, b + 108), 0);
    check("t3_ready_end", 2, hget(1, 2, b + 109), 1);

    // two stop bits
    send(3, 8'hFF, 0, a);
    wait_cycles(130);
    cnt = 0;
    for (int c = a + 90; c < a + 110; c++) cnt += (hget(0, 3, c) == 1) ? 1 : 0;
    check("t4_stop_high", 3, cnt, 20);
    check("t4_ready_pre", 3, hget(1, 3, a + 108), 0);
    check("t4_ready_end", 3, hget(1, 3, a + 109), 1);
    check("t4_idle", 3, hget(2, 3, a + 110), 0);

    // reset in the middle of data bit 3
    send(0, 8'h00, 0, a);
    wait_cycles(42);
    check("t5_pre_tx", 0, int'(tx_o[0]), 0);
    rst = 1'b1;
    #1;
    check("t5_async_tx", 0, int'(tx_o[0]), 1);
    wait_cycles(2);
    rst = 1'b0;
    r = n;
    wait_cycles(150);
    cnt = 0;
    for (int c = r; c < r + 150; c++) cnt += (hget(0, 0, c) == 0) ? 1 : 0;
    check("t5_no_edges", 0, cnt, 0);
    check("t5_ready", 0, hget(1, 0, r + 1), 1);
    check("t5_busy", 0, hget(2, 0, r + 1), 0);

    // tx_data changing every cycle, tx_valid held until three accepts
    data[0]  = 8'h3C;
    valid[0] = 1'b1;
    k = 0;
    for (int t = 0; t < 260; t++) begin
      @(negedge clk);
      if (rdy[0] && valid[0] && k < 3) begin
        acc_e[k] = n + 1;
        acc_d[k] = int'(data[0]);
        k++;
      end
      @(posedge clk);
      #2;
      data[0]  = data[0] + 8'h2B;
      valid[0] = (k < 3);
    end
    valid[0] = 1'b0;
    wait_cycles(120);
    check("t6_accepts", 0, k, 3);
    for (int j = 0; j < 3; j++)
      if (j < k) check("t6_byte", j, decode(0, acc_e[j]), acc_d[j]);
    check("t6_gap", 0, acc_e[1] - acc_e[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
